caravel_wb_bridge: RTL and testbench

Wishbone-classic slave that terminates the Caravel management-SoC bus inside soc and converts each access into a single valid/ready request on the SoC's internal memory port, or into an access to a small local CSR bank. It sits directly downstream of the Caravel Wishbone pins (caravel_wbs_*) and upstream of the SoC memory interconnect. It lets firmware load program memory, read it back, and hold the core in reset during loading.

---
 rtl/soc_pkg.sv | 42 ++++
 rtl/caravel_wb_csr.sv | 64 ++++++
 rtl/caravel_wb_bridge.sv | 143 ++++++++++++++
 tb/tb_caravel_wb_bridge.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared definitions for the Caravel Wishbone bridge: CSR address map,
// FSM state encoding and the latched memory-request record.
package soc_pkg;

  localparam logic [22:0] CSR_CTRL_OFF    = 23'h00_0000;
  localparam logic [22:0] CSR_STATUS_OFF  = 23'h00_0004;
  localparam logic [22:0] CSR_SCRATCH_OFF = 23'h00_0008;
  localparam int          WINDOW_SEL_BIT  = 23;
  localparam logic [31:0] TIMEOUT_DATA    = 32'hBAD0_0BAD;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    ACK,
    DONE
  } bridge_state_e;

  typedef enum logic [1:0] {
    TGT_MEM,
    TGT_CSR,
    TGT_NONE
  } target_e;

  // addr holds the full Wishbone word address; consumers slice what they need.
  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] upd,
                                              input logic [3:0]  sel);
    merge_bytes = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merge_bytes[8*b +: 8] = upd[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/caravel_wb_csr.sv
// Local CSR bank of the bridge: CTRL (core reset), STATUS (sticky timeout
// flag plus saturating timeout count, W1C) and a byte-writable SCRATCH word.
module caravel_wb_csr
  import soc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [22:0] offset,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        timeout_evt,
  output logic [31:0] rdata,
  output logic        core_reset,
  output logic        err
);

  logic [7:0]  timeout_count;
  logic [31:0] scratch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      core_reset    <= 1'b1;
      err           <= 1'b0;
      timeout_count <= '0;
      scratch       <= '0;
    end else begin
      if (timeout_evt) begin
        err           <= 1'b1;
        timeout_count <= sat_inc(timeout_count);
      end
      if (wr_en) begin
        case (offset)
          CSR_CTRL_OFF: begin
            if (wmask[0]) core_reset <= wdata[0];
          end
          CSR_STATUS_OFF: begin
            if (wmask[3] && wdata[31]) begin
              err           <= 1'b0;
              timeout_count <= '0;
            end
          end
          CSR_SCRATCH_OFF: scratch <= merge_bytes(scratch, wdata, wmask);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      CSR_CTRL_OFF:    rdata = {31'b0, core_reset};
      CSR_STATUS_OFF:  rdata = {err, 23'b0, timeout_count};
      CSR_SCRATCH_OFF: rdata = scratch;
      default:         rdata = '0;
    endcase
  end

endmodule

// File: rtl/caravel_wb_bridge.sv
// Wishbone-classic slave that turns each Caravel bus access into one
// valid/ready memory request or a local CSR access, with a wait timeout.
module caravel_wb_bridge
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          MEM_ADDR_W = 14,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_we_o,
  output logic [MEM_ADDR_W-1:0] mem_req_addr_o,
  output logic [31:0]           mem_req_wdata_o,
  output logic [3:0]            mem_req_wmask_o,
  input  logic                  mem_resp_valid_i,
  input  logic [31:0]           mem_resp_rdata_i,
  output logic                  core_reset_o,
  output logic                  err_o
);

  localparam logic [8:0] WAIT_LIMIT = 9'(TIMEOUT);

  bridge_state_e state;
  target_e       tgt;
  mem_req_t      req;
  logic [31:0]   resp_data;
  logic [31:0]   csr_rdata;
  logic [7:0]    wait_cnt;
  logic          wait_expired;
  logic          timeout_evt;
  logic          csr_wr;
  logic          unused_bits;

  // Abort once the number of cycles spent waiting reaches TIMEOUT.
  assign wait_expired = ({1'b0, wait_cnt} + 9'd1) == WAIT_LIMIT;
  assign csr_wr       = (state == ACK) && (tgt == TGT_CSR) && req.we;

  assign mem_req_we_o    = req.we;
  assign mem_req_addr_o  = req.addr[MEM_ADDR_W-1:0];
  assign mem_req_wdata_o = req.wdata;
  assign mem_req_wmask_o = req.wmask;
  assign unused_bits     = ^{wbs_adr_i[1:0], req.addr[29:21]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      tgt             <= TGT_NONE;
      wbs_ack_o       <= 1'b0;
      wbs_dat_o       <= '0;
      mem_req_valid_o <= 1'b0;
      wait_cnt        <= '0;
      timeout_evt     <= 1'b0;
      resp_data       <= '0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (wbs_stb_i && wbs_cyc_i) begin
            req       <= '{we: wbs_we_i, addr: wbs_adr_i[31:2],
                           wdata: wbs_dat_i, wmask: wbs_sel_i};
            resp_data <= '0;
            if (wbs_adr_i[31:24] != BASE_ADDR[31:24]) begin
              tgt   <= TGT_NONE;
              state <= ACK;
            end else if (wbs_adr_i[WINDOW_SEL_BIT]) begin
              tgt   <= TGT_CSR;
              state <= ACK;
            end else begin
              tgt             <= TGT_MEM;
              mem_req_valid_o <= 1'b1;
              wait_cnt        <= '0;
              state           <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            wait_cnt        <= '0;
            state           <= req.we ? ACK : RESP;
          end else if (wait_expired) begin
            mem_req_valid_o <= 1'b0;
            timeout_evt     <= 1'b1;
            resp_data       <= TIMEOUT_DATA;
            state           <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (mem_resp_valid_i) begin
            resp_data <= mem_resp_rdata_i;
            state     <= ACK;
          end else if (wait_expired) begin
            timeout_evt <= 1'b1;
            resp_data   <= TIMEOUT_DATA;
            state       <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ACK: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= (tgt == TGT_CSR && !req.we) ? csr_rdata : resp_data;
          state     <= DONE;
        end
        DONE: begin
          // Ack is on the bus this cycle; a strobe still high here is the
          // tail of the access just acknowledged, not a new one.
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  caravel_wb_csr u_csr (
    .clk         (clk_i),
    .rst         (rst_i),
    .wr_en       (csr_wr),
    .offset      ({req.addr[20:0], 2'b00}),
    .wdata       (req.wdata),
    .wmask       (req.wmask),
    .timeout_evt (timeout_evt),
    .rdata       (csr_rdata),
    .core_reset  (core_reset_o),
    .err         (err_o)
  );

endmodule

// File: tb/tb_caravel_wb_bridge.sv
// Bench for caravel_wb_bridge: directed bus scenarios plus randomized
// accesses checked against a word-level memory/CSR model.
module tb_caravel_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] rdat;
  logic        mem_valid, mem_ready, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        core_reset, err;

  always #5 clk = ~clk;

  caravel_wb_bridge dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .wbs_stb_i        (stb),
    .wbs_cyc_i        (cyc),
    .wbs_we_i         (we),
    .wbs_sel_i        (sel),
    .wbs_dat_i        (wdat),
    .wbs_adr_i        (adr),
    .wbs_ack_o        (ack),
    .wbs_dat_o        (rdat),
    .mem_req_valid_o  (mem_valid),
    .mem_req_ready_i  (mem_ready),
    .mem_req_we_o     (mem_we),
    .mem_req_addr_o   (mem_addr),
    .mem_req_wdata_o  (mem_wdata),
    .mem_req_wmask_o  (mem_wmask),
    .mem_resp_valid_i (resp_valid),
    .mem_resp_rdata_i (resp_rdata),
    .core_reset_o     (core_reset),
    .err_o            (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ack_total = 0;

  // Memory-side agent state
  int          rdy_dly, rsp_dly;
  bit          never_rdy;
  int          n_hs = 0, n_vld = 0;
  logic [31:0] store [0:63];
  logic [13:0] last_addr;
  logic [3:0]  last_mask;
  logic [31:0] last_wdata;

  // Reference model
  logic [31:0] model_mem [0:63];
  logic [31:0] model_scratch;
  logic        model_ctrl;

  logic [31:0] rd;
  int          lat, hs0, v0, a0;

  function automatic logic [31:0] init_val(input int i);
    return 32'(i) * 32'h0101_0101 ^ 32'h5A00_00C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] upd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = upd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (ack === 1'b1) ack_total++;

  // Wishbone master: holds stb one cycle past the visible ack like a real master.
  task automatic wb(input logic [31:0] a, input logic [31:0] d, input bit w,
                    input logic [3:0] s, output logic [31:0] r, output int l);
    adr = a; wdat = d; we = w; sel = s; stb = 1'b1; cyc = 1'b1;
    l = 0;
    while (l < 600) begin
      @(posedge clk); #1;
      l++;
      if (ack === 1'b1) break;
    end
    check("ack_seen", 32'(ack), 32'd1);
    r = rdat;
    @(posedge clk); #1;
    check("ack_single", 32'(ack), 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("no_dup_ack", 32'(ack), 32'd0);
    end
  endtask

  // Memory agent: accepts after rdy_dly cycles, answers reads after rsp_dly.
  initial begin : responder
    logic [50:0] cap;
    mem_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    for (int i = 0; i < 64; i++) store[i] = init_val(i);
    forever begin
      @(posedge clk); #1;
      if (mem_valid === 1'b1) begin
        cap = {mem_we, mem_addr, mem_wdata, mem_wmask};
        n_vld++;
        for (int i = 0; i < 1000; i++) begin
          if (!never_rdy && i >= rdy_dly) break;
          @(posedge clk); #1;
          if (mem_valid !== 1'b1) break;
          n_vld++;
          check("req_stable", 32'({mem_we, mem_addr, mem_wdata, mem_wmask} == cap), 32'd1);
        end
        if (mem_valid === 1'b1 && !never_rdy) begin
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
          n_hs++;
          last_addr = cap[49:36]; last_wdata = cap[35:4]; last_mask = cap[3:0];
          if (cap[50]) begin
            store[last_addr[5:0]] = merge(store[last_addr[5:0]], last_wdata, last_mask);
          end else begin
            for (int j = 0; j < rsp_dly; j++) begin @(posedge clk); #1; end
            resp_valid = 1'b1;
            resp_rdata = store[last_addr[5:0]];
            @(posedge clk); #1;
            resp_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; wdat = '0; adr = '0;
    rdy_dly = 0; rsp_dly = 0; never_rdy = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // CSR path
    wb(32'h3080_0000, 32'h0, 1'b0, 4'hF, rd, lat);
    check("ctrl_rd_lat", 32'(lat), 32'd2);
    check("ctrl_rd", rd, 32'h1);
    wb(32'h3080_0008, 32'hA5A5_1234, 1'b1, 4'b0011, rd, lat);
    wb(32'h3080_0008, 32'h0, 1'b0, 4'hF, rd, lat);
    check("scratch_rd", rd, 32'h0000_1234);
    model_scratch = 32'h0000_1234;
    wb(32'h3080_0000, 32'h0, 1'b1, 4'hF, rd, lat);
    check("ctrl_wr_core_reset", 32'(core_reset), 32'd0);
    model_ctrl = 1'b0;

    // Posted MEM write, ready on entry
    hs0 = n_hs; v0 = n_vld; rdy_dly = 0;
    wb(32'h3000_0010, 32'hCAFE_F00D, 1'b1, 4'hF, rd, lat);
    check("memwr_lat", 32'(lat), 32'd3);
    check("memwr_addr", 32'(last_addr), 32'd4);
    check("memwr_mask", 32'(last_mask), 32'hF);
    check("memwr_data", last_wdata, 32'hCAFE_F00D);
    check("memwr_hs", 32'(n_hs - hs0), 32'd1);
    check("memwr_vld_cycles", 32'(n_vld - v0), 32'd1);
    model_mem[4] = 32'hCAFE_F00D;

    // MEM read with slow ready and slow response
    rdy_dly = 5; rsp_dly = 2;
    wb(32'h3000_0004, 32'h0, 1'b0, 4'hF, rd, lat);
    check("memrd_slow_lat", 32'(lat), 32'd11);
    check("memrd_slow_data", rd, model_mem[1]);

    // Timeout
    never_rdy = 1'b1; hs0 = n_hs;
    wb(32'h3000_0020, 32'h0, 1'b0, 4'hF, rd, lat);
    never_rdy = 1'b0; rdy_dly = 0; rsp_dly = 0;
    check("timeout_lat", 32'(lat), 32'd257);
    check("timeout_data", rd, 32'hBAD0_0BAD);
    check("timeout_no_hs", 32'(n_hs - hs0), 32'd0);
    check("timeout_err", 32'(err), 32'd1);
    wb(32'h3080_0004, 32'h0, 1'b0, 4'hF, rd, lat);
    check("status_after_to", rd, 32'h8000_0001);
    wb(32'h3080_0004, 32'h8000_0000, 1'b1, 4'b1000, rd, lat);
    wb(32'h3080_0004, 32'h0, 1'b0, 4'hF, rd, lat);
    check("status_cleared", rd, 32'h0);
    check("err_cleared", 32'(err), 32'd0);

    // Outside the window
    hs0 = n_hs; v0 = n_vld;
    wb(32'h4000_0000, 32'h0, 1'b0, 4'hF, rd, lat);
    check("nomatch_data", rd, 32'h0);
    check("nomatch_lat", 32'(lat), 32'd2);
    check("nomatch_no_req", 32'(n_vld - v0), 32'd0);

    // Randomized mix against the model
    for (int t = 0; t < 40; t++) begin
      int          kind, sub, w, rdy, rsp;
      logic [31:0] a, d;
      logic [3:0]  s;
      kind = $urandom_range(0, 5);
      w = $urandom_range(0, 15);
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      rdy = $urandom_range(0, 3);
      rsp = $urandom_range(0, 3);
      a = 32'h3000_0000 | (32'($urandom_range(0, 127)) << 16) | (32'(w) << 2);
      hs0 = n_hs; v0 = n_vld;
      rdy_dly = rdy; rsp_dly = rsp;
      if (kind <= 1) begin
        wb(a, d, 1'b1, s, rd, lat);
        model_mem[w] = merge(model_mem[w], d, s);
        check("rnd_wr_lat", 32'(lat), 32'(3 + rdy));
        check("rnd_wr_addr", 32'(last_addr), 32'(w));
        check("rnd_wr_mask", 32'(last_mask), 32'(s));
        check("rnd_wr_data", last_wdata, d);
        check("rnd_wr_hs", 32'(n_hs - hs0), 32'd1);
      end else if (kind <= 3) begin
        wb(a, 32'h0, 1'b0, 4'hF, rd, lat);
        check("rnd_rd_lat", 32'(lat), 32'(4 + rdy + rsp));
        check("rnd_rd_data", rd, model_mem[w]);
      end else if (kind == 4) begin
        sub = $urandom_range(0, 4);
        case (sub)
          0: begin
            wb(32'h3080_0008, d, 1'b1, s, rd, lat);
            model_scratch = merge(model_scratch, d, s);
          end
          1: begin
            wb(32'h3080_0008, 32'h0, 1'b0, 4'hF, rd, lat);
            check("rnd_scratch", rd, model_scratch);
          end
          2: begin
            wb(32'h3080_0000, d, 1'b1, s, rd, lat);
            if (s[0]) model_ctrl = d[0];
            check("rnd_core_reset", 32'(core_reset), 32'(model_ctrl));
          end
          3: begin
            wb(32'h3080_0004, 32'h0, 1'b0, 4'hF, rd, lat);
            check("rnd_status", rd, 32'h0);
          end
          default: begin
            wb(32'h3080_000C, d, 1'b1, 4'hF, rd, lat);
            wb(32'h3080_000C, 32'h0, 1'b0, 4'hF, rd, lat);
            check("rnd_unmapped", rd, 32'h0);
          end
        endcase
        check("rnd_csr_lat", 32'(lat), 32'd2);
        check("rnd_csr_no_req", 32'(n_vld - v0), 32'd0);
      end else begin
        a[31:24] = 8'($urandom_range(0, 255));
        if (a[31:24] == 8'h30) a[31:24] = 8'h31;
        wb(a, d, (d[0] == 1'b1), s, rd, lat);
        if (d[0] == 1'b0) check("rnd_nomatch_data", rd, 32'h0);
        check("rnd_nomatch_lat", 32'(lat), 32'd2);
        check("rnd_nomatch_no_req", 32'(n_vld - v0), 32'd0);
      end
    end

    // Reset while waiting for a read response
    rdy_dly = 0; rsp_dly = 20;
    adr = 32'h3000_0008; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("resp_wait_valid_low", 32'(mem_valid), 32'd0);
    a0 = ack_total;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_valid", 32'(mem_valid), 32'd0);
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_ack", 32'(ack_total - a0), 32'd0);
    rsp_dly = 0;
    wb(32'h3080_0008, 32'h0, 1'b0, 4'hF, rd, lat);
    check("midrst_scratch", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
